// File: rtl/scan_pkg.sv
// Shared scan/image constants and FSM state type for the IMEM -> rgb2hsv read path.
package scan_pkg;

  localparam int unsigned SCAN_WIDTH  = 400;
  localparam int unsigned SCAN_HEIGHT = 400;
  localparam int unsigned SCAN_ADDR_W = 18;
  localparam int unsigned SCAN_XW     = 9;
  localparam int unsigned SCAN_YW     = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // y * w as a shift-add over the set bits of the constant w; used only at frame load
  function automatic logic [31:0] row_offset(input logic [31:0] y, input int unsigned w);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < 32; i++) begin
      if (w[i]) acc = acc + (y << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/scan_ctrl_wrap_cnt.sv
// Loadable up-counter that wraps back to its base value after reaching wrap_at.
module wrap_cnt #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] base,
  input  logic [W-1:0] wrap_at,
  output logic [W-1:0] cnt,
  output logic         term
);

  assign term = (cnt == wrap_at);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= base;
    end else if (en) begin
      cnt <= term ? base : cnt + W'(1);
    end
  end

endmodule

// File: rtl/scan_ctrl.sv
// Raster-order frame scan controller with valid/ready pixel-address output.
// Optional region-of-interest window enabled by defining SCAN_ROI_EN.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int unsigned WIDTH  = SCAN_WIDTH,
  parameter int unsigned HEIGHT = SCAN_HEIGHT,
  parameter int unsigned ADDR_W = SCAN_ADDR_W,
  parameter int unsigned XW     = SCAN_XW,
  parameter int unsigned YW     = SCAN_YW
) (
  input  logic              CLK,
  input  logic              Reset_0,
  input  logic              Start,
  input  logic              Abort,
  input  logic              Ready,
`ifdef SCAN_ROI_EN
  input  logic [XW-1:0]     RoiX0,
  input  logic [XW-1:0]     RoiX1,
  input  logic [YW-1:0]     RoiY0,
  input  logic [YW-1:0]     RoiY1,
`endif
  output logic [ADDR_W-1:0] Addr,
  output logic              Valid,
  output logic [XW-1:0]     X,
  output logic [YW-1:0]     Y,
  output logic              Sof,
  output logic              Eol,
  output logic              Eof,
  output logic              Busy,
  output logic              Done
);

  scan_state_e state_q, state_d;
  logic valid_d, busy_d, done_d;

  logic [XW-1:0] x0, x1, x_load;
  logic [YW-1:0] y0, y1, y_load;
  logic          roi_bad;
  logic          start_req, accept, x_term, y_term;
  logic [ADDR_W-1:0] rowbase_q;

  assign start_req = (state_q == IDLE) && Start;
  assign accept    = (state_q == SCAN) && Ready;

`ifdef SCAN_ROI_EN
  // Window bounds captured on the accepted Start; inputs feed the load path directly
  assign roi_bad = (RoiX1 < RoiX0) || (RoiY1 < RoiY0) ||
                   (32'(RoiX1) >= 32'(WIDTH)) || (32'(RoiY1) >= 32'(HEIGHT));
  assign x_load  = (state_q == IDLE) ? RoiX0 : x0;
  assign y_load  = (state_q == IDLE) ? RoiY0 : y0;

  always_ff @(posedge CLK or posedge Reset_0) begin
    if (Reset_0) begin
      x0 <= '0;
      x1 <= XW'(WIDTH - 1);
      y0 <= '0;
      y1 <= YW'(HEIGHT - 1);
    end else if (start_req) begin
      x0 <= RoiX0;
      x1 <= RoiX1;
      y0 <= RoiY0;
      y1 <= RoiY1;
    end
  end
`else
  assign roi_bad = 1'b0;
  assign x0      = '0;
  assign x1      = XW'(WIDTH - 1);
  assign y0      = '0;
  assign y1      = YW'(HEIGHT - 1);
  assign x_load  = x0;
  assign y_load  = y0;
`endif

  wrap_cnt #(.W(XW)) u_x_cnt (
    .clk     (CLK),
    .rst     (Reset_0),
    .load    (start_req),
    .en      (accept),
    .base    (x_load),
    .wrap_at (x1),
    .cnt     (X),
    .term    (x_term)
  );

  wrap_cnt #(.W(YW)) u_y_cnt (
    .clk     (CLK),
    .rst     (Reset_0),
    .load    (start_req),
    .en      (accept && x_term),
    .base    (y_load),
    .wrap_at (y1),
    .cnt     (Y),
    .term    (y_term)
  );

  // Addr advances by one inside a line; at end of line it jumps from the row base
  always_ff @(posedge CLK or posedge Reset_0) begin
    if (Reset_0) begin
      Addr      <= '0;
      rowbase_q <= '0;
    end else if (start_req) begin
      rowbase_q <= ADDR_W'(row_offset(32'(y_load), WIDTH));
      Addr      <= ADDR_W'(row_offset(32'(y_load), WIDTH)) + ADDR_W'(x_load);
    end else if (accept) begin
      if (x_term) begin
        rowbase_q <= rowbase_q + ADDR_W'(WIDTH);
        Addr      <= rowbase_q + ADDR_W'(WIDTH) + ADDR_W'(x0);
      end else begin
        Addr <= Addr + ADDR_W'(1);
      end
    end
  end

  // State and registered status outputs
  always_ff @(posedge CLK or posedge Reset_0) begin
    if (Reset_0) begin
      state_q <= IDLE;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      Valid   <= valid_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (Start) state_d = roi_bad ? DONE : SCAN;
      SCAN: begin
        if (Abort) state_d = IDLE;
        else if (accept && x_term && y_term) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_d)
      SCAN: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
      end
      DONE:    done_d = 1'b1;
      default: ;
    endcase
  end

  assign Sof = Valid && (X == x0) && (Y == y0);
  assign Eol = Valid && x_term;
  assign Eof = Valid && x_term && y_term;

endmodule

// File: tb/tb_scan_ctrl.sv
// Scoreboard bench for scan_ctrl: stimulus queues expected beats, a negedge monitor checks them.
module tb_scan_ctrl;
  localparam int unsigned W  = 400;
  localparam int unsigned H  = 24;
  localparam int unsigned AW = 18;
  localparam int unsigned XW = 9;
  localparam int unsigned YW = 9;
  localparam int N = W * H;

  logic CLK = 1'b0;
  logic Reset_0, Start, Abort, Ready;
  logic [AW-1:0] Addr;
  logic Valid, Sof, Eol, Eof, Busy, Done;
  logic [XW-1:0] X;
  logic [YW-1:0] Y;
`ifdef SCAN_ROI_EN
  logic [XW-1:0] RoiX0, RoiX1;
  logic [YW-1:0] RoiY0, RoiY1;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic sof, eol, eof;
  } beat_t;

  beat_t sb[$];
  int tests = 0, fails = 0, cyc = 0;
  int done_count = 0, done_cyc = -1, acc_count = 0, last_acc = -1, stalls = 0;
  bit bp = 1'b0;

  scan_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .XW(XW), .YW(YW)) dut (
    .CLK(CLK), .Reset_0(Reset_0), .Start(Start), .Abort(Abort), .Ready(Ready),
`ifdef SCAN_ROI_EN
    .RoiX0(RoiX0), .RoiX1(RoiX1), .RoiY0(RoiY0), .RoiY1(RoiY1),
`endif
    .Addr(Addr), .Valid(Valid), .X(X), .Y(Y), .Sof(Sof), .Eol(Eol), .Eof(Eof),
    .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, need 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pops one expected beat per accepted transfer, checks hold stability under stall
  beat_t cur, expv, prev;
  bit prev_hold = 1'b0;
  always @(negedge CLK) begin
    cur = {Addr, X, Y, Sof, Eol, Eof};
    chk("busy_vs_valid", 64'(Busy), 64'(Valid));
    if (prev_hold && Valid) chk("stall_hold", 64'(cur), 64'(prev));
    if (Valid && sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_beat: addr %0d x %0d y %0d, none expected", Addr, X, Y);
    end else if (Valid && Ready) begin
      expv = sb.pop_front();
      chk("beat", 64'(cur), 64'(expv));
    end
    if (Valid && Ready) begin
      acc_count++;
      last_acc = cyc;
    end
    if (Valid && !Ready) stalls++;
    if (Done) begin
      done_count++;
      done_cyc = cyc;
    end
    prev = cur;
    prev_hold = Valid && !Ready;
  end

  initial begin
    Ready = 1'b1;
    forever begin
      @(posedge CLK);
      #1;
      Ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic push_beat(input int a, input int x, input int y,
                           input bit s, input bit l, input bit f);
    beat_t b;
    b.addr = AW'(a);
    b.x = XW'(x);
    b.y = YW'(y);
    b.sof = s;
    b.eol = l;
    b.eof = f;
    sb.push_back(b);
  endtask

  task automatic push_window(input int x0, input int x1, input int y0, input int y1);
    for (int y = y0; y <= y1; y++)
      for (int x = x0; x <= x1; x++)
        push_beat(y * W + x, x, y, (x == x0) && (y == y0), x == x1, (x == x1) && (y == y1));
  endtask

  task automatic pulse_start(output int n);
    @(posedge CLK);
    #1 Start = 1'b1;
    n = cyc;
    @(posedge CLK);
    #1 Start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_count == d0 && k < budget) begin
      @(posedge CLK);
      k++;
    end
    #1;
    if (done_count == d0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: no Done within %0d cycles", budget);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, 64'(Addr), 64'(0));
    chk({tag, "_xy"}, 64'({X, Y}), 64'(0));
    chk({tag, "_flags"}, 64'({Valid, Sof, Eol, Eof, Busy, Done}), 64'(0));
  endtask

  int n, d0, a0, s0;

  initial begin
    Start = 1'b0;
    Abort = 1'b0;
    Reset_0 = 1'b1;
`ifdef SCAN_ROI_EN
    RoiX0 = '0; RoiX1 = XW'(W - 1); RoiY0 = '0; RoiY1 = YW'(H - 1);
`endif
    repeat (3) @(posedge CLK);
    #1 chk_reset_outputs("reset");
    Reset_0 = 1'b0;
    repeat (2) @(posedge CLK);

    // Full frame, Ready high; Start raised during the DONE cycle must be ignored
    push_window(0, W - 1, 0, H - 1);
    d0 = done_count;
    pulse_start(n);
    chk("first_valid", 64'(Valid), 64'(1));
    repeat (N) @(posedge CLK);
    #1 Start = 1'b1;
    chk("done_pulse", 64'(Done), 64'(1));
    chk("done_valid_low", 64'(Valid), 64'(0));
    @(posedge CLK);
    #1 Start = 1'b0;
    chk("start_in_done_ignored", 64'({Valid, Busy, Done}), 64'(0));
    repeat (2) @(posedge CLK);
    #1 chk("idle_after_done", 64'(Valid), 64'(0));
    chk("done_cycle", 64'(done_cyc), 64'(n + N + 1));
    chk("done_once", 64'(done_count), 64'(d0 + 1));
    chk("frame_drained", 64'(sb.size()), 64'(0));

    // Abort while Addr 1234 is presented
    push_window(0, W - 1, 0, H - 1);
    while (sb.size() > 1235) void'(sb.pop_back());
    d0 = done_count;
    pulse_start(n);
    repeat (1234) @(posedge CLK);
    #1 chk("abort_addr", 64'(Addr), 64'(1234));
    Abort = 1'b1;
    @(posedge CLK);
    #1 Abort = 1'b0;
    chk("abort_idle", 64'({Valid, Busy}), 64'(0));
    repeat (4) @(posedge CLK);
    #1 chk("abort_no_done", 64'(done_count), 64'(d0));
    chk("abort_drained", 64'(sb.size()), 64'(0));

    // Restart after abort under random backpressure
    push_window(0, W - 1, 0, H - 1);
    d0 = done_count;
    a0 = acc_count;
    s0 = stalls;
    bp = 1'b1;
    pulse_start(n);
    wait_done(d0, 4 * N);
    bp = 1'b0;
    chk("bp_done_after_eof", 64'(done_cyc), 64'(last_acc + 1));
    chk("bp_beats", 64'(acc_count - a0), 64'(N));
    chk("bp_length", 64'(done_cyc - n), 64'(N + (stalls - s0) + 1));
    chk("bp_drained", 64'(sb.size()), 64'(0));

    // Asynchronous reset mid-frame
    push_window(0, W - 1, 0, H - 1);
    pulse_start(n);
    repeat (500) @(posedge CLK);
    #3 Reset_0 = 1'b1;
    #1 chk_reset_outputs("async_reset");
    sb.delete();
    #2 Reset_0 = 1'b0;
    @(posedge CLK);
    #1 chk("post_reset_idle", 64'(Valid), 64'(0));

`ifdef SCAN_ROI_EN
    // ROI window (10,20)-(12,21)
    RoiX0 = 9'd10; RoiX1 = 9'd12; RoiY0 = 9'd20; RoiY1 = 9'd21;
    push_beat(8010, 10, 20, 1, 0, 0);
    push_beat(8011, 11, 20, 0, 0, 0);
    push_beat(8012, 12, 20, 0, 1, 0);
    push_beat(8410, 10, 21, 0, 0, 0);
    push_beat(8411, 11, 21, 0, 0, 0);
    push_beat(8412, 12, 21, 0, 1, 1);
    d0 = done_count;
    pulse_start(n);
    wait_done(d0, 50);
    chk("roi_done_cycle", 64'(done_cyc), 64'(n + 7));
    chk("roi_drained", 64'(sb.size()), 64'(0));

    // Invalid ROI: X1 beyond the line
    RoiX1 = 9'd400;
    d0 = done_count;
    a0 = acc_count;
    pulse_start(n);
    chk("bad_roi_done", 64'({Done, Valid}), 64'(2));
    @(posedge CLK);
    #1 chk("bad_roi_after", 64'({Done, Valid}), 64'(0));
    chk("bad_roi_no_beats", 64'(acc_count), 64'(a0));
    chk("bad_roi_done_count", 64'(done_count), 64'(d0 + 1));
`endif

    repeat (2) @(posedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_ctrl.md
# scan_ctrl

Frame scan controller that sequences the image-memory read path feeding the RGB-to-HSV converter. On a start request it walks the image in raster order, presenting one pixel address per accepted beat with a valid/ready handshake so downstream stages can stall. It reports raster coordinates and frame/line markers, then signals completion. It replaces the free-running address counter in front of the IMEM/rgb2hsv datapath.

## Interface
- WIDTH, 400: pixels per line.
- HEIGHT, 400: lines per frame.
- ADDR_W, 18: address width; WIDTH*HEIGHT must fit.
- XW / YW, 9 / 9: coordinate widths; must hold WIDTH-1 and HEIGHT-1.

Ports:
- CLK  in  1  single clock, rising edge.
- Reset_0  in  1  reset, asynchronous, active-high.
- Start  in  1  frame request; sampled only in IDLE.
- Abort  in  1  cancel the current frame; sampled in SCAN.
- Ready  in  1  downstream accepts the current beat.
- Addr  out  ADDR_W  IMEM pixel address.
- Valid  out  1  Addr/X/Y/markers are meaningful.
- X  out  XW  current column.
- Y  out  YW  current line.
- Sof / Eol / Eof  out  1 each  first pixel / last pixel of line / last pixel of frame; qualified by Valid.
- Busy  out  1  high in SCAN.
- Done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - Valid=0, Busy=0.
  - Start=1 loads X=x0, Y=y0, Addr=y0*WIDTH+x0 and moves to SCAN.
- SCAN:
  - Valid=1, Busy=1.
  - A beat is accepted when Valid&&Ready. On accept: if X!=xend, X+1 and Addr+1.
  - At end of line: X=x0, Y+1, and Addr=rowbase+WIDTH+x0, where rowbase is a register holding Y*WIDTH.
  - No multiplier. Addr is maintained incrementally.
- Ready=0 holds Addr, X, Y and all markers stable. Valid stays 1; Valid never drops mid-frame.
- Marker decode:
  - Sof = (X==x0 && Y==y0).
  - Eol = (X==xend).
  - Eof = Eol && (Y==yend).
- Accept with Eof=1 moves to DONE.
- DONE lasts one cycle: Done=1, Valid=0, Busy=0, then IDLE. Start is ignored in DONE.
- Abort=1 in SCAN moves to IDLE next cycle; no Done. Abort overrides a simultaneous final accept: no Done.
- Start during SCAN/DONE and Abort in IDLE/DONE are ignored.
- Without ROI: x0=0, y0=0, xend=WIDTH-1, yend=HEIGHT-1.
- Reset mid-frame: immediate return to IDLE. Reset values: Addr=0, X=0, Y=0, Valid=0, Sof=Eol=Eof=0, Busy=0, Done=0.

## Timing
- Start high in IDLE at cycle n gives Valid=1, Addr=first pixel at n+1. IMEM is combinational, so pixel data is aligned with Addr.
- With Ready tied high, a full 400x400 frame is 160000 beats on cycles n+1..n+160000. Done is high at n+160001. The next Start is accepted at n+160002 at the earliest.
- Each Ready-low cycle adds exactly one cycle to the frame.
- All outputs are registered or decoded only from registered state. No input-to-output combinational path.

## Configuration
- SCAN_ROI_EN defined:
  - Adds inputs RoiX0, RoiX1 (XW) and RoiY0, RoiY1 (YW), latched on accepted Start.
  - Scans only the inclusive window; Addr stays the full-image address.
  - If RoiX1<RoiX0, RoiY1<RoiY0, RoiX1>=WIDTH or RoiY1>=HEIGHT, Start goes directly to DONE: Done pulse, zero beats, Valid never high.
- SCAN_ROI_EN undefined: no ROI ports; full frame always.

## Structure
- Shared package scan_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - default WIDTH/HEIGHT/ADDR_W constants, also used by the IMEM wrapper and the HSV datapath.
- One natural sub-module: wrap_cnt, a loadable counter with enable, wrap value and terminal flag. It is instantiated for X and Y.
- Addr and rowbase registers stay in scan_ctrl.

## Test plan
- Full frame, Ready=1: Start at cycle 5. Expect Addr 0..159999 on cycles 6..160005. Sof only at Addr 0. Eol at every Addr%400==399. Eof at Addr 159999. Done at cycle 160006 only.
- Backpressure: Ready random 50%. Expect Addr/X/Y stable whenever Ready=0, no skipped or repeated accepted address, accepted-beat count 160000, and Done one cycle after the Eof accept.
- Line wrap: at X=399, Y=0, accept. Expect next X=0, Y=1, Addr=400.
- Abort at Addr 1234 with Ready=1. Expect Valid=0 and Busy=0 next cycle, Done never asserted, and a new Start restarting at Addr 0.
- Reset_0 pulsed mid-frame, asynchronous to CLK. Expect all outputs at reset values immediately. Start during the DONE cycle is ignored.
- SCAN_ROI_EN with ROI (10,20)-(12,21). Expect Addr sequence 8010, 8011, 8012, 8410, 8411, 8412, then Done. Invalid ROI X1=400 gives Done with zero Valid beats.
